// File: rtl/mem_port_arbiter.sv
// Two-requester (host UART controller / NN engine) arbiter onto a BRAM array and one SPRAM.
// Optional BRAM select range checking is enabled by defining MEM_ARB_RANGE_CHECK_EN.
module mem_port_arbiter #(
  parameter int MEM_SELECT_BITS = 5,
  parameter int NUM_BRAM        = 30
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [MEM_SELECT_BITS-1:0] h_select,
  input  logic [7:0]                 h_addr,
  input  logic [13:0]                h_sp_addr,
  input  logic                       h_spram,
  input  logic [15:0]                h_wdata,
  input  logic                       h_rd_en,
  input  logic                       h_wr_en,
  output logic [15:0]                h_rdata,
  output logic                       h_rvalid,
  input  logic                       n_req,
  input  logic                       n_we,
  input  logic [MEM_SELECT_BITS-1:0] n_select,
  input  logic [7:0]                 n_addr,
  input  logic [13:0]                n_sp_addr,
  input  logic                       n_spram,
  input  logic [15:0]                n_wdata,
  output logic                       n_gnt,
  output logic [15:0]                n_rdata,
  output logic                       n_rvalid,
  output logic [MEM_SELECT_BITS-1:0] m_select,
  output logic [7:0]                 m_addr,
  output logic [15:0]                m_wdata,
  output logic                       m_re,
  output logic                       m_we,
  input  logic [15:0]                m_rdata,
  output logic [13:0]                s_addr,
  output logic [15:0]                s_wdata,
  output logic                       s_cs,
  output logic                       s_we,
  input  logic [15:0]                s_rdata,
  output logic                       err
);

`ifdef MEM_ARB_RANGE_CHECK_EN
  localparam bit RangeCheckEn = 1'b1;
`else
  localparam bit RangeCheckEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                       host_act;
  logic                       accept;
  logic                       win_host;
  logic                       win_write;
  logic                       win_spram;
  logic                       win_drop;
  logic [MEM_SELECT_BITS-1:0] win_select;
  logic [7:0]                 win_addr;
  logic [13:0]                win_sp_addr;
  logic [15:0]                win_wdata;

  logic [MEM_SELECT_BITS-1:0] m_select_q, m_select_d;
  logic [7:0]                 m_addr_q, m_addr_d;
  logic [15:0]                m_wdata_q, m_wdata_d;
  logic                       m_re_q, m_re_d;
  logic                       m_we_q, m_we_d;
  logic [13:0]                s_addr_q, s_addr_d;
  logic [15:0]                s_wdata_q, s_wdata_d;
  logic                       s_cs_q, s_cs_d;
  logic                       s_we_q, s_we_d;

  logic iss_rd_q, iss_rd_d;
  logic iss_host_q, iss_host_d;
  logic iss_spram_q, iss_spram_d;
  logic iss_drop_q, iss_drop_d;
  logic cap_valid_q, cap_valid_d;
  logic cap_host_q, cap_host_d;
  logic cap_spram_q, cap_spram_d;
  logic cap_drop_q, cap_drop_d;

  logic [15:0] cap_data;
  logic [15:0] h_rdata_q, h_rdata_d;
  logic [15:0] n_rdata_q, n_rdata_d;
  logic        err_q, err_d;

  // Host always wins; the pipeline takes one access per cycle, so the issue stage is never busy.
  always_comb begin
    host_act    = h_rd_en | h_wr_en;
    n_gnt       = n_req & ~host_act & ~reset;
    accept      = (host_act | n_req) & ~reset;
    win_host    = host_act;
    win_write   = host_act ? h_wr_en : n_we;
    win_spram   = host_act ? h_spram : n_spram;
    win_select  = host_act ? h_select : n_select;
    win_addr    = host_act ? h_addr : n_addr;
    win_sp_addr = host_act ? h_sp_addr : n_sp_addr;
    win_wdata   = host_act ? h_wdata : n_wdata;
    win_drop    = RangeCheckEn && !win_spram && (32'(win_select) >= 32'(NUM_BRAM));
  end

  always_comb begin
    state_d = IDLE;
    if (accept) begin
      state_d = ISSUE;
    end else if (state_q == ISSUE && iss_rd_q) begin
      state_d = CAPTURE;
    end
  end

  always_comb begin
    m_select_d  = m_select_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    m_re_d      = 1'b0;
    m_we_d      = 1'b0;
    s_cs_d      = 1'b0;
    s_we_d      = 1'b0;
    iss_rd_d    = 1'b0;
    iss_host_d  = win_host;
    iss_spram_d = win_spram;
    iss_drop_d  = win_drop;
    if (accept) begin
      iss_rd_d = ~win_write;
      if (win_spram) begin
        s_addr_d  = win_sp_addr;
        s_wdata_d = win_wdata;
        s_cs_d    = 1'b1;
        s_we_d    = win_write;
      end else begin
        m_select_d = win_select;
        m_addr_d   = win_addr;
        m_wdata_d  = win_wdata;
        m_re_d     = ~win_write & ~win_drop;
        m_we_d     = win_write & ~win_drop;
      end
    end
    cap_valid_d = iss_rd_q;
    cap_host_d  = iss_host_q;
    cap_spram_d = iss_spram_q;
    cap_drop_d  = iss_drop_q;
    err_d       = err_q | (accept & win_drop);
  end

  // Memory data arrives in the capture cycle; it is forwarded at once and held afterwards.
  always_comb begin
    cap_data  = cap_drop_q ? 16'h0000 : (cap_spram_q ? s_rdata : m_rdata);
    h_rvalid  = cap_valid_q & cap_host_q & ~reset;
    n_rvalid  = cap_valid_q & ~cap_host_q & ~reset;
    h_rdata_d = h_rvalid ? cap_data : h_rdata_q;
    n_rdata_d = n_rvalid ? cap_data : n_rdata_q;
    h_rdata   = reset ? 16'h0000 : h_rdata_d;
    n_rdata   = reset ? 16'h0000 : n_rdata_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      m_select_q  <= '0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_re_q      <= 1'b0;
      m_we_q      <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_cs_q      <= 1'b0;
      s_we_q      <= 1'b0;
      iss_rd_q    <= 1'b0;
      iss_host_q  <= 1'b0;
      iss_spram_q <= 1'b0;
      iss_drop_q  <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_host_q  <= 1'b0;
      cap_spram_q <= 1'b0;
      cap_drop_q  <= 1'b0;
      h_rdata_q   <= '0;
      n_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_select_q  <= m_select_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_re_q      <= m_re_d;
      m_we_q      <= m_we_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_cs_q      <= s_cs_d;
      s_we_q      <= s_we_d;
      iss_rd_q    <= iss_rd_d;
      iss_host_q  <= iss_host_d;
      iss_spram_q <= iss_spram_d;
      iss_drop_q  <= iss_drop_d;
      cap_valid_q <= cap_valid_d;
      cap_host_q  <= cap_host_d;
      cap_spram_q <= cap_spram_d;
      cap_drop_q  <= cap_drop_d;
      h_rdata_q   <= h_rdata_d;
      n_rdata_q   <= n_rdata_d;
      err_q       <= err_d;
    end
  end

  assign m_select = m_select_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_re     = m_re_q;
  assign m_we     = m_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_cs     = s_cs_q;
  assign s_we     = s_we_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter with a read-data scoreboard per requester;
// the range-check expectations follow MEM_ARB_RANGE_CHECK_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  h_select, n_select, m_select;
  logic [7:0]  h_addr, n_addr, m_addr;
  logic [13:0] h_sp_addr, n_sp_addr, s_addr;
  logic        h_spram, n_spram;
  logic [15:0] h_wdata, n_wdata, h_rdata, n_rdata, m_wdata, s_wdata;
  logic [15:0] m_rdata, s_rdata;
  logic        h_rd_en, h_wr_en, h_rvalid, n_req, n_we, n_gnt, n_rvalid;
  logic        m_re, m_we, s_cs, s_we, err;

  int compared = 0;
  int mismatched = 0;
  int cycleCount = 0;
  int hostLast = 0;
  int nnLast = 0;
  int nnRvCount = 0;
  logic [15:0] hostExp[$];
  logic [15:0] nnExp[$];

  logic [15:0] bramMem [32][256] = '{default: '{default: 16'h0000}};
  logic [15:0] spramMem [16384] = '{default: 16'h0000};

  typedef struct {
    logic        isHost;
    logic        bothStrobes;
    logic        we;
    logic        spram;
    logic [4:0]  sel;
    logic [7:0]  addr;
    logic [13:0] spAddr;
    logic [15:0] wdata;
    logic        expMre;
    logic        expMwe;
    logic        expScs;
    logic        expSwe;
    logic [15:0] expRdata;
  } vec_t;

  vec_t vecs[14];

  mem_port_arbiter #(.MEM_SELECT_BITS(5), .NUM_BRAM(30)) dut (
    .clk(clk), .reset(reset),
    .h_select(h_select), .h_addr(h_addr), .h_sp_addr(h_sp_addr), .h_spram(h_spram),
    .h_wdata(h_wdata), .h_rd_en(h_rd_en), .h_wr_en(h_wr_en),
    .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .n_req(n_req), .n_we(n_we), .n_select(n_select), .n_addr(n_addr),
    .n_sp_addr(n_sp_addr), .n_spram(n_spram), .n_wdata(n_wdata),
    .n_gnt(n_gnt), .n_rdata(n_rdata), .n_rvalid(n_rvalid),
    .m_select(m_select), .m_addr(m_addr), .m_wdata(m_wdata), .m_re(m_re), .m_we(m_we),
    .m_rdata(m_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_cs(s_cs), .s_we(s_we), .s_rdata(s_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous memories: read data appears the cycle after the enable.
  always @(posedge clk) begin
    if (m_we) bramMem[m_select][m_addr] <= m_wdata;
    if (m_re) m_rdata <= bramMem[m_select][m_addr];
    if (s_cs && s_we) spramMem[s_addr] <= s_wdata;
    if (s_cs && !s_we) s_rdata <= spramMem[s_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every rvalid pulse must match the oldest outstanding expected read.
  always @(negedge clk) begin
    cycleCount++;
    if (h_rvalid === 1'b1) begin
      hostLast = cycleCount;
      if (hostExp.size() == 0) checkOutput("h_rvalid_unexpected", 1, 0);
      else checkOutput("h_rdata", h_rdata, hostExp.pop_front());
    end
    if (n_rvalid === 1'b1) begin
      nnLast = cycleCount;
      nnRvCount++;
      if (nnExp.size() == 0) checkOutput("n_rvalid_unexpected", 1, 0);
      else checkOutput("n_rdata", n_rdata, nnExp.pop_front());
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    h_rd_en = 0; h_wr_en = 0; n_req = 0; n_we = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_m_en"}, {m_re, m_we, s_cs, s_we}, 0);
    checkOutput({tag, "_valids"}, {n_gnt, h_rvalid, n_rvalid, err}, 0);
    checkOutput({tag, "_rdata"}, {h_rdata, n_rdata}, 0);
    checkOutput({tag, "_maddr"}, {m_select, m_addr, m_wdata}, 0);
    checkOutput({tag, "_saddr"}, {s_addr, s_wdata}, 0);
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((hostExp.size() != 0 || nnExp.size() != 0) && n < 50) begin
      nextCycle();
      n++;
    end
    checkOutput({tag, "_drain_outstanding"}, hostExp.size() + nnExp.size(), 0);
    nextCycle();
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isHost) begin
      h_select = v.sel; h_addr = v.addr; h_sp_addr = v.spAddr; h_spram = v.spram; h_wdata = v.wdata;
      h_wr_en = v.we;
      h_rd_en = !v.we || v.bothStrobes;
      if (!v.we) hostExp.push_back(v.expRdata);
    end else begin
      n_select = v.sel; n_addr = v.addr; n_sp_addr = v.spAddr; n_spram = v.spram; n_wdata = v.wdata;
      n_req = 1; n_we = v.we;
      if (!v.we) nnExp.push_back(v.expRdata);
    end
  endtask

  initial begin
    int c0;
    int cnt0;
    vecs[0]  = '{1, 0, 1, 0, 5'd3,  8'h10, 14'h0,    16'hBEEF, 0, 1, 0, 0, 16'h0};
    vecs[1]  = '{1, 0, 0, 0, 5'd3,  8'h10, 14'h0,    16'h0,    1, 0, 0, 0, 16'hBEEF};
    vecs[2]  = '{0, 0, 1, 1, 5'd0,  8'h00, 14'h3FFF, 16'h1234, 0, 0, 1, 1, 16'h0};
    vecs[3]  = '{1, 0, 0, 1, 5'd0,  8'h00, 14'h3FFF, 16'h0,    0, 0, 1, 0, 16'h1234};
    vecs[4]  = '{0, 0, 1, 0, 5'd0,  8'h00, 14'h0,    16'hA000, 0, 1, 0, 0, 16'h0};
    vecs[5]  = '{0, 0, 1, 0, 5'd0,  8'h01, 14'h0,    16'hA001, 0, 1, 0, 0, 16'h0};
    vecs[6]  = '{0, 0, 1, 0, 5'd0,  8'h02, 14'h0,    16'hA002, 0, 1, 0, 0, 16'h0};
    vecs[7]  = '{0, 0, 1, 0, 5'd0,  8'h03, 14'h0,    16'hA003, 0, 1, 0, 0, 16'h0};
    vecs[8]  = '{1, 1, 1, 0, 5'd5,  8'h20, 14'h0,    16'h5555, 0, 1, 0, 0, 16'h0};
    vecs[9]  = '{1, 0, 0, 0, 5'd5,  8'h20, 14'h0,    16'h0,    1, 0, 0, 0, 16'h5555};
    vecs[10] = '{0, 0, 1, 1, 5'd0,  8'h00, 14'h0100, 16'h7777, 0, 0, 1, 1, 16'h0};
    vecs[11] = '{0, 0, 0, 1, 5'd0,  8'h00, 14'h0100, 16'h0,    0, 0, 1, 0, 16'h7777};
    vecs[12] = '{1, 0, 1, 0, 5'd29, 8'hFF, 14'h0,    16'h2929, 0, 1, 0, 0, 16'h0};
    vecs[13] = '{0, 0, 0, 0, 5'd29, 8'hFF, 14'h0,    16'h0,    1, 0, 0, 0, 16'h2929};

    reset = 1;
    h_select = 0; h_addr = 0; h_sp_addr = 0; h_spram = 0; h_wdata = 0;
    n_select = 0; n_addr = 0; n_sp_addr = 0; n_spram = 0; n_wdata = 0;
    idleInputs();
    repeat (3) nextCycle();
    reset = 0;
    nextCycle();
    checkAllZero("reset_state");

    // Single transactions from the table, one idle cycle between each.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      if (!vecs[i].isHost) checkOutput($sformatf("v%0d_n_gnt", i), n_gnt, 1);
      nextCycle();
      idleInputs();
      checkOutput($sformatf("v%0d_enables", i), {m_re, m_we, s_cs, s_we},
                  {vecs[i].expMre, vecs[i].expMwe, vecs[i].expScs, vecs[i].expSwe});
      if (vecs[i].expMwe) checkOutput($sformatf("v%0d_bram_wr", i), {m_select, m_addr, m_wdata},
                                      {vecs[i].sel, vecs[i].addr, vecs[i].wdata});
      if (vecs[i].expMre) checkOutput($sformatf("v%0d_bram_rd", i), {m_select, m_addr},
                                      {vecs[i].sel, vecs[i].addr});
      if (vecs[i].expScs) checkOutput($sformatf("v%0d_spram", i), {s_addr, s_wdata},
                                      {vecs[i].spAddr, vecs[i].expSwe ? vecs[i].wdata : s_wdata});
      nextCycle();
    end
    waitDrain("table");

    // Host strobe and NN request collide: host goes first, NN granted next cycle.
    c0 = cycleCount;
    h_select = 5'd3; h_addr = 8'h10; h_spram = 0; h_rd_en = 1;
    n_select = 5'd0; n_addr = 8'h00; n_spram = 0; n_we = 0; n_req = 1;
    hostExp.push_back(16'hBEEF);
    nnExp.push_back(16'hA000);
    @(negedge clk);
    checkOutput("collide_n_gnt_first", n_gnt, 0);
    nextCycle();
    h_rd_en = 0;
    checkOutput("collide_host_issued", m_re, 1);
    @(negedge clk);
    checkOutput("collide_n_gnt_second", n_gnt, 1);
    nextCycle();
    idleInputs();
    waitDrain("collide");
    checkOutput("collide_host_latency", hostLast, c0 + 3);
    checkOutput("collide_nn_latency", nnLast, c0 + 4);

    // Four back-to-back NN reads.
    c0 = cycleCount;
    cnt0 = nnRvCount;
    for (int i = 0; i < 4; i++) begin
      n_req = 1; n_we = 0; n_spram = 0; n_select = 5'd0; n_addr = 8'(i);
      nnExp.push_back(16'hA000 + 16'(i));
      @(negedge clk);
      checkOutput($sformatf("b2b_n_gnt%0d", i), n_gnt, 1);
      nextCycle();
    end
    idleInputs();
    waitDrain("b2b");
    checkOutput("b2b_pulse_count", nnRvCount - cnt0, 4);
    checkOutput("b2b_last_pulse", nnLast, c0 + 6);

    // Out-of-range BRAM select.
    h_select = 5'd31; h_addr = 8'h00; h_spram = 0; h_rd_en = 1;
    hostExp.push_back(16'h0000);
    nextCycle();
    idleInputs();
`ifdef MEM_ARB_RANGE_CHECK_EN
    checkOutput("range_m_re", m_re, 0);
    checkOutput("range_err", err, 1);
`else
    checkOutput("range_m_re", m_re, 1);
    checkOutput("range_err", err, 0);
`endif
    waitDrain("range");
`ifdef MEM_ARB_RANGE_CHECK_EN
    checkOutput("range_err_sticky", err, 1);
`else
    checkOutput("range_err_tied", err, 0);
`endif

    // Reset lands in the capture cycle of a host read: the read must vanish.
    h_select = 5'd3; h_addr = 8'h10; h_spram = 0; h_rd_en = 1;
    nextCycle();
    idleInputs();
    nextCycle();
    reset = 1;
    nextCycle();
    reset = 0;
    checkAllZero("reset_capture");
    c0 = hostLast;
    repeat (5) nextCycle();
    checkOutput("reset_no_h_rvalid", hostLast, c0);
    checkAllZero("reset_quiet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
